// File: rtl/instr_realign_pipe.sv
// Instruction re-aligner: splits fetch blocks into RVC/RVI instructions and
// carries a straddling 32-bit lower half into the next block.
module instr_realign_pipe #(
  parameter int FETCH_WIDTH = 32,
  parameter int VLEN        = 39,
  parameter int NPAR        = FETCH_WIDTH / 16,
  parameter int OFF         = $clog2(FETCH_WIDTH / 8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [VLEN-1:0]        address_i,
  input  logic [FETCH_WIDTH-1:0] data_i,
  output logic [NPAR-1:0]        valid_o,
  output logic [NPAR*VLEN-1:0]   addr_o,
  output logic [NPAR*32-1:0]     instr_o,
  input  logic                   out_ready_i,
  output logic                   serving_unaligned_o
);

  localparam int PW = OFF - 1;
  localparam int SW = (NPAR > 1) ? $clog2(NPAR) : 1;

  logic [15:0]     par [NPAR];
  logic [PW-1:0]   start;
  logic [NPAR-1:0] slot_valid;
  logic [31:0]     slot_instr [NPAR];
  logic [VLEN-1:0] slot_addr [NPAR];
  logic [SW-1:0]   k;
  int              nxt;

  logic            unaligned_q, unaligned_d;
  logic [15:0]     unaligned_instr_q, unaligned_instr_d;
  logic [VLEN-1:0] unaligned_address_q, unaligned_address_d;

  logic [NPAR-1:0] valid_q;
  logic [31:0]     instr_q [NPAR];
  logic [VLEN-1:0] addr_q [NPAR];

  logic accept;
  logic unused_addr_lsb;

  assign unused_addr_lsb = address_i[0];
  assign start           = address_i[OFF-1:1];

  always_comb begin
    for (int p = 0; p < NPAR; p++) begin
      par[p] = data_i[16*p +: 16];
    end
  end

  // Scan parcels from the start offset; nxt is the next parcel that begins
  // an instruction, k the next free output slot.
  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < NPAR; i++) begin
      slot_instr[i] = '0;
      slot_addr[i]  = '0;
    end
    unaligned_d         = 1'b0;
    unaligned_instr_d   = unaligned_instr_q;
    unaligned_address_d = unaligned_address_q;
    k   = '0;
    nxt = int'(start);

    if (unaligned_q && start == '0) begin
      slot_valid[0] = 1'b1;
      slot_instr[0] = {par[0], unaligned_instr_q};
      slot_addr[0]  = unaligned_address_q;
      k   = SW'(1);
      nxt = 1;
    end

    for (int p = 0; p < NPAR; p++) begin
      if (p == nxt) begin
        if (par[p][1:0] != 2'b11) begin
          slot_valid[k] = 1'b1;
          slot_instr[k] = {16'h0, par[p]};
          slot_addr[k]  = {address_i[VLEN-1:OFF], PW'(p), 1'b0};
          k   = k + SW'(1);
          nxt = p + 1;
        end else if (p < NPAR - 1) begin
          slot_valid[k] = 1'b1;
          slot_instr[k] = {par[(p+1) % NPAR], par[p]};
          slot_addr[k]  = {address_i[VLEN-1:OFF], PW'(p), 1'b0};
          k   = k + SW'(1);
          nxt = p + 2;
        end else begin
          unaligned_d         = 1'b1;
          unaligned_instr_d   = par[p];
          unaligned_address_d = {address_i[VLEN-1:OFF], PW'(p), 1'b0};
        end
      end
    end
  end

  assign ready_o = flush_i || !(|valid_q) || out_ready_i;
  assign accept  = valid_i && ready_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q             <= '0;
      unaligned_q         <= 1'b0;
      unaligned_instr_q   <= '0;
      unaligned_address_q <= '0;
      for (int i = 0; i < NPAR; i++) begin
        instr_q[i] <= '0;
        addr_q[i]  <= '0;
      end
    end else if (flush_i) begin
      valid_q     <= '0;
      unaligned_q <= 1'b0;
      for (int i = 0; i < NPAR; i++) begin
        instr_q[i] <= '0;
        addr_q[i]  <= '0;
      end
    end else begin
      if (|valid_q && out_ready_i) begin
        valid_q <= '0;
        for (int i = 0; i < NPAR; i++) begin
          instr_q[i] <= '0;
          addr_q[i]  <= '0;
        end
      end
      // A new bundle overrides the consume-clear above in the same edge.
      if (accept) begin
        unaligned_q         <= unaligned_d;
        unaligned_instr_q   <= unaligned_instr_d;
        unaligned_address_q <= unaligned_address_d;
        if (|slot_valid) begin
          valid_q <= slot_valid;
          for (int i = 0; i < NPAR; i++) begin
            instr_q[i] <= slot_instr[i];
            addr_q[i]  <= slot_addr[i];
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NPAR; i++) begin
      instr_o[32*i +: 32]    = instr_q[i];
      addr_o[VLEN*i +: VLEN] = addr_q[i];
    end
  end

  assign valid_o             = valid_q;
  assign serving_unaligned_o = unaligned_q;

endmodule

// File: tb/tb_instr_realign_pipe.sv
// Directed bench for instr_realign_pipe: 32-bit and 64-bit instances side by side.
module tb_instr_realign_pipe;
  localparam int VLEN = 39;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_i, flush_i, out_ready_i, v32_i, v64_i, sel64;
  logic [VLEN-1:0] address_i;
  logic [63:0] data_i;
  logic rdy32, rdy64, su32, su64;
  logic [1:0] vo32;
  logic [3:0] vo64;
  logic [2*VLEN-1:0] ao32;
  logic [4*VLEN-1:0] ao64;
  logic [63:0] io32;
  logic [127:0] io64;

  instr_realign_pipe #(.FETCH_WIDTH(32), .VLEN(VLEN)) u32 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(v32_i), .ready_o(rdy32),
    .address_i(address_i), .data_i(data_i[31:0]), .valid_o(vo32), .addr_o(ao32),
    .instr_o(io32), .out_ready_i(out_ready_i), .serving_unaligned_o(su32));

  instr_realign_pipe #(.FETCH_WIDTH(64), .VLEN(VLEN)) u64 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(v64_i), .ready_o(rdy64),
    .address_i(address_i), .data_i(data_i), .valid_o(vo64), .addr_o(ao64),
    .instr_o(io64), .out_ready_i(out_ready_i), .serving_unaligned_o(su64));

  logic [3:0] cur_valid;
  logic [127:0] cur_instr;
  logic [155:0] cur_addr;
  logic cur_su, cur_rdy;

  always_comb begin
    cur_valid = sel64 ? vo64 : {2'b00, vo32};
    cur_instr = sel64 ? io64 : {64'h0, io32};
    cur_addr  = sel64 ? ao64 : {78'h0, ao32};
    cur_su    = sel64 ? su64 : su32;
    cur_rdy   = sel64 ? rdy64 : rdy32;
  end

  typedef struct packed {
    logic         w64;
    logic [38:0]  addr;
    logic [63:0]  data;
    logic [3:0]   ev;
    logic [127:0] ei;
    logic [155:0] ea;
    logic         eu;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic w, logic [38:0] a, logic [63:0] d, logic [3:0] ev,
                              logic [31:0] i0, logic [31:0] i1, logic [31:0] i2, logic [31:0] i3,
                              logic [38:0] a0, logic [38:0] a1, logic [38:0] a2, logic [38:0] a3,
                              logic eu);
    vec_t v;
    v.w64 = w; v.addr = a; v.data = d; v.ev = ev;
    v.ei = {i3, i2, i1, i0};
    v.ea = {a3, a2, a1, a0};
    v.eu = eu;
    return v;
  endfunction

  task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_bundle(string nm, vec_t e);
    chk({nm, "_valid"}, {156'h0, cur_valid}, {156'h0, e.ev});
    chk({nm, "_instr"}, {32'h0, cur_instr}, {32'h0, e.ei});
    chk({nm, "_addr"},  {4'h0, cur_addr},   {4'h0, e.ea});
    chk({nm, "_su"},    {159'h0, cur_su},   {159'h0, e.eu});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  vec_t tv [12];
  vec_t e;

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1; v32_i = 1'b0; v64_i = 1'b0;
    sel64 = 1'b0; address_i = '0; data_i = '0;

    tv[0]  = mk(0, 'h1000, 'h45014501, 4'b0011, 'h4501, 'h4501, 0, 0, 'h1000, 'h1002, 0, 0, 0);
    tv[1]  = mk(0, 'h2000, 'h05134501, 4'b0001, 'h4501, 0, 0, 0, 'h2000, 0, 0, 0, 1);
    tv[2]  = mk(0, 'h2004, 'h00000000, 4'b0011, 'h0513, 0, 0, 0, 'h2002, 'h2006, 0, 0, 0);
    tv[3]  = mk(0, 'h2102, 'h00134501, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tv[4]  = mk(0, 'h2202, 'h00010513, 4'b0001, 'h0001, 0, 0, 0, 'h2202, 0, 0, 0, 0);
    tv[5]  = mk(0, 'h2300, 'h00000513, 4'b0001, 'h0513, 0, 0, 0, 'h2300, 0, 0, 0, 0);
    tv[6]  = mk(1, 'h1000, 64'h4501_0000_0513_0001, 4'b0111, 'h0001, 'h0513, 'h4501, 0,
                'h1000, 'h1002, 'h1006, 0, 0);
    tv[7]  = mk(1, 'h3006, 64'h0513_0000_0000_0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tv[8]  = mk(1, 'h3008, 64'h0, 4'b1111, 'h0513, 0, 0, 0, 'h3006, 'h300a, 'h300c, 'h300e, 0);
    tv[9]  = mk(1, 'h5004, 64'h1234_0017_ffff_ffff, 4'b0001, 'h12340017, 0, 0, 0,
                'h5004, 0, 0, 0, 0);
    tv[10] = mk(1, 'h6000, 64'h0003_0002_0001_0000, 4'b0111, 0, 1, 2, 0,
                'h6000, 'h6002, 'h6004, 0, 1);
    tv[11] = mk(1, 'h6008, 64'h0, 4'b1111, 'h0003, 0, 0, 0, 'h6006, 'h600a, 'h600c, 'h600e, 0);

    tick(); tick();
    rst_i = 1'b0;
    e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sel64 = 1'b0; #1;
    chk_bundle("reset32", e);
    sel64 = 1'b1; #1;
    chk_bundle("reset64", e);

    for (int i = 0; i < 12; i++) begin
      address_i = tv[i].addr;
      data_i    = tv[i].data;
      sel64     = tv[i].w64;
      v32_i     = !tv[i].w64;
      v64_i     = tv[i].w64;
      #1;
      chk($sformatf("v%0d_ready", i), {159'h0, cur_rdy}, 160'h1);
      tick();
      v32_i = 1'b0; v64_i = 1'b0;
      chk_bundle($sformatf("v%0d", i), tv[i]);
    end

    // Backpressure: bundle A held for three cycles while block B waits.
    sel64 = 1'b0; out_ready_i = 1'b1;
    address_i = 'h7000; data_i = 'h45014501; v32_i = 1'b1;
    tick();
    e = mk(0, 0, 0, 4'b0011, 'h4501, 'h4501, 0, 0, 'h7000, 'h7002, 0, 0, 0);
    chk_bundle("bp_a", e);
    out_ready_i = 1'b0;
    address_i = 'h7004; data_i = 'h00050009;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_ready_%0d", c), {159'h0, rdy32}, 160'h0);
      tick();
      chk_bundle($sformatf("bp_hold_%0d", c), e);
    end
    out_ready_i = 1'b1; #1;
    chk("bp_release_ready", {159'h0, rdy32}, 160'h1);
    tick();
    v32_i = 1'b0;
    e = mk(0, 0, 0, 4'b0011, 'h0009, 'h0005, 0, 0, 'h7004, 'h7006, 0, 0, 0);
    chk_bundle("bp_b", e);
    tick();
    e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_bundle("bp_drain", e);

    // Flush with a pending bundle and a carried half.
    address_i = 'h8000; data_i = 'h05134501; v32_i = 1'b1;
    tick();
    out_ready_i = 1'b0; v32_i = 1'b0;
    e = mk(0, 0, 0, 4'b0001, 'h4501, 0, 0, 0, 'h8000, 0, 0, 0, 1);
    chk_bundle("fl_pre", e);
    flush_i = 1'b1; v32_i = 1'b1; address_i = 'h8004; data_i = 'hffffffff;
    #1;
    chk("fl_ready", {159'h0, rdy32}, 160'h1);
    tick();
    flush_i = 1'b0; v32_i = 1'b0;
    e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_bundle("fl_post", e);
    out_ready_i = 1'b1;
    address_i = 'h4000; data_i = 'h00000513; v32_i = 1'b1;
    tick();
    v32_i = 1'b0;
    e = mk(0, 0, 0, 4'b0001, 'h0513, 0, 0, 0, 'h4000, 0, 0, 0, 0);
    chk_bundle("fl_fresh", e);

    // Reset mid-stream on the 64-bit instance.
    sel64 = 1'b1;
    address_i = 'h6000; data_i = 64'h0003_0002_0001_0000; v64_i = 1'b1;
    tick();
    chk_bundle("rs_pre", tv[10]);
    out_ready_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; v64_i = 1'b0;
    e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_bundle("rs_post64", e);
    sel64 = 1'b0; #1;
    chk_bundle("rs_post32", e);
    sel64 = 1'b1; out_ready_i = 1'b1;
    address_i = 'h6008; data_i = 64'h0; v64_i = 1'b1;
    tick();
    v64_i = 1'b0;
    e = mk(1, 0, 0, 4'b1111, 0, 0, 0, 0, 'h6008, 'h600a, 'h600c, 'h600e, 0);
    chk_bundle("rs_fresh", e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
